bias_fetch_ctrl: RTL

Sequencer that walks the 128-entry, 4-read-port bias memory and streams bias words to the accumulator/activation stage, four words per beat. The host gives a base index and a bias count. The block drives the four read addresses and registers the returned 128-bit word. It presents each word on a valid/ready output with a per-lane mask and a last flag. It sits between the layer controller and the bias memory.

---
 rtl/bias_fetch_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bias_fetch_ctrl.sv
// Bias fetch sequencer: walks the 4-port bias memory from a base index and
// streams four bias words per beat on a valid/ready output with lane mask and last flag.
module bias_fetch_ctrl #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [AW-1:0]       base_idx,
  input  logic [7:0]          num_bias,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       a1,
  output logic [AW-1:0]       a2,
  output logic [AW-1:0]       a3,
  output logic [AW-1:0]       a4,
  input  logic [LANES*DW-1:0] bias_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] out_data,
  output logic [LANES-1:0]    out_lane_mask,
  output logic                out_last
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [7:0]          rem_q, rem_d;
  logic                valid_q, valid_d;
  logic [LANES*DW-1:0] data_q, data_d;
  logic [LANES-1:0]    mask_q, mask_d;
  logic                last_q, last_d;

  logic                hs;
  logic                accept;
  logic                capture;
  logic [7:0]          num_clamped;
  logic [LANES*DW-1:0] lane_data;
  logic [LANES-1:0]    lane_hit;

  assign hs          = valid_q & out_ready;
  assign num_clamped = (num_bias > 8'(DEPTH)) ? 8'(DEPTH) : num_bias;
  assign accept      = (state_q == S_IDLE) & start & ~abort;
  // A beat is captured on entry (FETCH) and on every non-final handshake, so a
  // consumer holding ready high sees one beat per cycle.
  assign capture     = ~abort & ((state_q == S_FETCH) |
                                 ((state_q == S_OUT) & hs & ~last_q));

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_hit[gi] = (rem_q > 8'(gi));
      assign lane_data[gi*DW +: DW] = lane_hit[gi] ? bias_in[gi*DW +: DW] : '0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (num_clamped == 8'd0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_OUT;
      S_OUT:   if (hs && last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    a1   = ptr_q;
    a2   = ptr_q + AW'(1);
    a3   = ptr_q + AW'(2);
    a4   = ptr_q + AW'(3);
  end

  always_comb begin
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    data_d  = data_q;
    mask_d  = mask_q;
    last_d  = last_q;
    if (accept) begin
      ptr_d = base_idx;
      rem_d = num_clamped;
    end
    if (capture) begin
      data_d  = lane_data;
      mask_d  = lane_hit;
      last_d  = (rem_q <= 8'(LANES));
      ptr_d   = ptr_q + AW'(LANES);
      rem_d   = (rem_q >= 8'(LANES)) ? rem_q - 8'(LANES) : 8'd0;
      valid_d = 1'b1;
    end else if (state_q == S_OUT && hs && last_q) begin
      valid_d = 1'b0;
    end
    if (abort && state_q != S_IDLE) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      mask_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_lane_mask = mask_q;
  assign out_last      = last_q;

endmodule
